i2s_tdm_clock_gen: RTL and testbench

//  Master-mode audio bit/frame clock generator for I2S, left-justified and TDM links.

---
 rtl/i2s_tdm_clock_gen.sv | 175 +++++++++++++++++
 tb/tb_i2s_tdm_clock_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_clock_gen.sv
// Master-mode I2S / left-justified / TDM bit and frame clock generator with slot/bit position and SCK edge strobes.
// Optional I2S_CLKGEN_FRAME_CNT_EN adds a 16-bit frames-started counter on frame_cnt_o.
module i2s_tdm_clock_gen #(
  parameter int DIV_W     = 8,
  parameter int SLOT_BITS = 32,
  parameter int NUM_SLOTS = 2,
  parameter int WS_MODE   = 0,
  parameter int WS_DELAY1 = 1,
  parameter int WS_POL    = 0,
  localparam int SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int BIT_W    = $clog2(SLOT_BITS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [DIV_W-1:0]  div_i,
  output logic              sck_o,
  output logic              ws_o,
  output logic              sck_rise_o,
  output logic              sck_fall_o,
  output logic              frame_start_o,
  output logic [SLOT_W-1:0] slot_idx_o,
  output logic [BIT_W-1:0]  bit_idx_o,
  output logic              busy_o
`ifdef I2S_CLKGEN_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt_o
`endif
);

  localparam int FRAME = NUM_SLOTS * SLOT_BITS;
  localparam int P_W   = $clog2(FRAME) + 1;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d, d_q, d_d;
  logic               sck_q, sck_d, ws_q, ws_d;
  logic               rise_q, rise_d, fall_q, fall_d, fs_q, fs_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DIV_W-1:0]   d_clamp, hi_len, lo_len;
  logic               wrap;
  logic [P_W-1:0]     p_next;

  function automatic logic ws_of(input logic [P_W-1:0] p);
    logic [P_W-1:0] q;
    q = p + P_W'(WS_DELAY1);
    if (q >= P_W'(FRAME)) q = q - P_W'(FRAME);
    if (WS_MODE == 0) ws_of = (q < P_W'(FRAME / 2)) ? 1'(WS_POL) : ~1'(WS_POL);
    else              ws_of = (q == '0) ? ~1'(WS_POL) : 1'(WS_POL);
  endfunction

  assign d_clamp = (div_i < DIV_W'(2)) ? DIV_W'(2) : div_i;
  assign hi_len  = d_q >> 1;
  assign lo_len  = d_q - hi_len;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    sck_d   = sck_q;
    ws_d    = ws_q;
    slot_d  = slot_q;
    bit_d   = bit_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    fs_d    = 1'b0;
    wrap    = 1'b0;
    p_next  = '0;
    case (state_q)
      IDLE: begin
        sck_d  = 1'b0;
        ws_d   = 1'(WS_POL);
        cnt_d  = '0;
        slot_d = '0;
        bit_d  = '0;
        if (enable_i) begin
          state_d = RUN;
          d_d     = d_clamp;
          ws_d    = ws_of('0);
          fs_d    = 1'b1;
          fall_d  = 1'b1;
        end
      end
      default: begin
        if (state_q == RUN && !enable_i)      state_d = STOPPING;
        if (state_q == STOPPING && enable_i)  state_d = RUN;
        if (!sck_q) begin
          if (cnt_q == lo_len - DIV_W'(1)) begin
            sck_d  = 1'b1;
            cnt_d  = '0;
            rise_d = 1'b1;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end else if (cnt_q == hi_len - DIV_W'(1)) begin
          sck_d  = 1'b0;
          cnt_d  = '0;
          fall_d = 1'b1;
          if (bit_q == BIT_W'(SLOT_BITS - 1)) begin
            bit_d = '0;
            if (slot_q == SLOT_W'(NUM_SLOTS - 1)) begin
              slot_d = '0;
              wrap   = 1'b1;
            end else begin
              slot_d = slot_q + SLOT_W'(1);
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
          p_next = P_W'(slot_d) * P_W'(SLOT_BITS) + P_W'(bit_d);
          ws_d   = ws_of(p_next);
          // Frame boundary: a pending stop ends here, otherwise a new frame begins with a fresh divider.
          if (wrap) begin
            if (state_q == STOPPING && !enable_i) begin
              state_d = IDLE;
              ws_d    = 1'(WS_POL);
            end else begin
              fs_d = 1'b1;
              d_d  = d_clamp;
            end
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'(WS_POL);
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      fs_q    <= 1'b0;
      slot_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      fs_q    <= fs_d;
      slot_q  <= slot_d;
      bit_q   <= bit_d;
    end
  end

`ifdef I2S_CLKGEN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   frame_cnt_q <= '0;
    else if (fs_d) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_cnt_o = frame_cnt_q;
`endif

  assign sck_o         = sck_q;
  assign ws_o          = ws_q;
  assign sck_rise_o    = rise_q;
  assign sck_fall_o    = fall_q;
  assign frame_start_o = fs_q;
  assign slot_idx_o    = slot_q;
  assign bit_idx_o     = bit_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_i2s_tdm_clock_gen.sv
// Directed bench: I2S-style instance (2x16, WS delayed) and TDM instance (8x32, 1-SCK FSYNC) driven side by side.
module tb_i2s_tdm_clock_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] div;

  logic       sck0, ws0, rise0, fall0, fs0, busy0;
  logic [0:0] slot0;
  logic [3:0] bit0;
  logic       sck1, ws1, rise1, fall1, fs1, busy1;
  logic [2:0] slot1;
  logic [4:0] bit1;
`ifdef I2S_CLKGEN_FRAME_CNT_EN
  logic [15:0] fcnt0, fcnt1;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2s_tdm_clock_gen #(.DIV_W(8), .SLOT_BITS(16), .NUM_SLOTS(2), .WS_MODE(0), .WS_DELAY1(1), .WS_POL(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .div_i(div),
    .sck_o(sck0), .ws_o(ws0), .sck_rise_o(rise0), .sck_fall_o(fall0), .frame_start_o(fs0),
    .slot_idx_o(slot0), .bit_idx_o(bit0), .busy_o(busy0)
`ifdef I2S_CLKGEN_FRAME_CNT_EN
    , .frame_cnt_o(fcnt0)
`endif
  );

  i2s_tdm_clock_gen #(.DIV_W(8), .SLOT_BITS(32), .NUM_SLOTS(8), .WS_MODE(1), .WS_DELAY1(0), .WS_POL(0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .div_i(div),
    .sck_o(sck1), .ws_o(ws1), .sck_rise_o(rise1), .sck_fall_o(fall1), .frame_start_o(fs1),
    .slot_idx_o(slot1), .bit_idx_o(bit1), .busy_o(busy1)
`ifdef I2S_CLKGEN_FRAME_CNT_EN
    , .frame_cnt_o(fcnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [7:0] d);
    rst_n = 1'b0;
    div   = d;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] dlist [2];
    int         n, fs_seen, rise_seen;
    logic       found;

    dlist[0] = 8'd0;
    dlist[1] = 8'd1;
    rst_n = 1'b0;
    en    = 1'b0;
    div   = 8'd8;
    tick();
    tick();
    chk("rst_sck", sck0, 0);
    chk("rst_ws", ws0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_fs", fs0, 0);
    chk("rst_strobes", {rise0, fall0}, 0);
    chk("rst_pos", {slot0, bit0}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy0, 0);
    en = 1'b1;
    tick();

    // Phase A: D=8 on both instances, divider change to 4 in dut0's second frame.
    for (int c = 0; c <= 2050; c++) begin
      case (c)
        0: begin
          chk("start_fs", fs0, 1);
          chk("start_fall", fall0, 1);
          chk("start_sck", sck0, 0);
          chk("start_busy", busy0, 1);
          chk("start_ws", ws0, 0);
          chk("tdm_start_ws", ws1, 1);
          chk("tdm_start_fs", fs1, 1);
        end
        3:    chk("d8_low_c3", sck0, 0);
        4:    chk("d8_rise_c4", {sck0, rise0}, 2'b11);
        7: begin
          chk("d8_high_c7", sck0, 1);
          chk("tdm_ws_c7", ws1, 1);
        end
        8: begin
          chk("d8_fall_c8", {sck0, fall0}, 2'b01);
          chk("d8_bit1", bit0, 1);
          chk("tdm_ws_c8", ws1, 0);
        end
        119:  chk("ws_before_p15", ws0, 0);
        120:  chk("ws_at_p15", ws0, 1);
        247:  chk("ws_before_p31", ws0, 1);
        248:  chk("ws_at_p31", {ws0, slot0, bit0}, {1'b0, 1'b1, 4'd15});
        255: begin
          chk("fs_c255", fs0, 0);
          chk("tdm_slot_c255", slot1, 0);
        end
        256: begin
          chk("frame_c256", {fs0, fall0, ws0, slot0, bit0}, {1'b1, 1'b1, 1'b0, 5'd0});
          chk("tdm_slot_c256", {slot1, bit1}, {3'd1, 5'd0});
`ifdef I2S_CLKGEN_FRAME_CNT_EN
          chk("fcnt_c256", fcnt0, 2);
`endif
        end
        300:  div = 8'd4;
        511:  chk("old_div_high_c511", sck0, 1);
        512:  chk("frame_c512", {fs0, sck0}, 2'b10);
        513:  chk("d4_low_c513", sck0, 0);
        514:  chk("d4_rise_c514", {sck0, rise0}, 2'b11);
        516:  chk("d4_fall_c516", {sck0, bit0}, {1'b0, 4'd1});
        639:  chk("fs_c639", fs0, 0);
        640:  chk("frame_c640", fs0, 1);
        2047: chk("tdm_fs_c2047", {fs1, ws1}, 2'b00);
        2048: chk("tdm_frame_c2048", {fs1, ws1, slot1}, {2'b11, 3'd0});
        default: ;
      endcase
      tick();
    end

    // Asynchronous reset in the middle of a high phase.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (sck0) found = 1'b1;
      else tick();
    end
    chk("high_phase_seen", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sck", sck0, 0);
    chk("async_rst_state", {busy0, fs0, ws0, slot0, bit0}, 0);
`ifdef I2S_CLKGEN_FRAME_CNT_EN
    chk("async_rst_fcnt", fcnt0, 0);
`endif
    div = 8'd5;
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_fs", {fs0, busy0, sck0}, 3'b110);
`ifdef I2S_CLKGEN_FRAME_CNT_EN
    chk("restart_fcnt", fcnt0, 1);
`endif
    for (int c = 1; c <= 5; c++) begin
      tick();
      case (c)
        2: chk("d5_low_c2", sck0, 0);
        3: chk("d5_rise_c3", {sck0, rise0}, 2'b11);
        4: chk("d5_high_c4", sck0, 1);
        5: chk("d5_fall_c5", {sck0, fall0, bit0}, {2'b01, 4'd1});
        default: ;
      endcase
    end

    // D of 0 and 1 behave as 2.
    for (int k = 0; k < 2; k++) begin
      restart(dlist[k]);
      chk($sformatf("d%0d_c0", k), {fs0, sck0}, 2'b10);
      tick();
      chk($sformatf("d%0d_c1", k), {sck0, rise0}, 2'b11);
      tick();
      chk($sformatf("d%0d_c2", k), {sck0, fall0, bit0}, {2'b01, 4'd1});
    end

    // Stop request at p=10 completes the frame, then idles without a frame start.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (slot0 == 1'b0 && bit0 == 4'd10) found = 1'b1;
      else tick();
    end
    chk("p10_seen", found, 1);
    en = 1'b0;
    n = 0;
    fs_seen = 0;
    while (busy0 && n < 200) begin
      tick();
      n++;
      if (fs0) fs_seen++;
    end
    chk("stop_cycles", n, 44);
    chk("stop_no_fs", fs_seen, 0);
    chk("stop_idle_out", {sck0, ws0, slot0, bit0}, 0);
`ifdef I2S_CLKGEN_FRAME_CNT_EN
    chk("stop_fcnt_hold", fcnt0, 1);
`endif
    rise_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rise0 || sck0 || busy0) rise_seen++;
    end
    chk("idle_quiet", rise_seen, 0);
    en = 1'b1;
    tick();
    chk("rerun_fs", {fs0, busy0}, 2'b11);
`ifdef I2S_CLKGEN_FRAME_CNT_EN
    chk("rerun_fcnt", fcnt0, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
